// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the producer-side valid/ready/data signals and the FIFO write-port
//   signals shared between the write arbiter and its environment.
//
//   Signals
//     req_valid  NREQ         per-producer data valid
//     req_data   NREQ*DWIDTH  producer i data at [i*DWIDTH +: DWIDTH]
//     req_ready  NREQ         per-producer beat accepted this cycle
//     fifo_full  1            FIFO full flag
//     fifo_din   DWIDTH       FIFO write data
//     fifo_w_en  1            FIFO write enable
//     gnt        NREQ         one-hot current grant, zero when idle
//     busy       1            a grant is held
//
//   Modports
//     master  environment side (producers + FIFO)
//     slave   arbiter side
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   fifo_full;
    logic [DWIDTH-1:0]      fifo_din;
    logic                   fifo_w_en;
    logic [NREQ-1:0]        gnt;
    logic                   busy;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_din, fifo_w_en, gnt, busy
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_din, fifo_w_en, gnt, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter that shares the single write port of a synchronous FIFO
//   among NREQ producers. One producer holds the grant for up to MAXBURST beats,
//   then priority rotates to the next index. Because the FIFO writes on w_en
//   regardless of full, this block never asserts fifo_w_en while fifo_full.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     bus        fifo_wr_arbiter_if.slave (producer handshakes + FIFO write port)
//     stall_cnt  16-bit saturating count of full stalls   (ARB_STATS_EN only)
//     beat_total 16-bit saturating count of FIFO writes   (ARB_STATS_EN only)
//
//   Optional feature macro: ARB_STATS_EN
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DWIDTH   = 8,
    parameter int MAXBURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    fifo_wr_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      beat_total
`endif
);
    localparam int IDXW = $clog2(NREQ);
    localparam int CNTW = $clog2(MAXBURST + 1);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREQ - 1);
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAXBURST - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t            state_q;
    logic [IDXW-1:0]   rr_ptr_q;
    logic [IDXW-1:0]   gnt_idx_q;
    logic [CNTW-1:0]   beat_cnt_q;
    logic [NREQ-1:0]   gnt_q;
    logic              busy_q;

    logic              pick_found;
    logic [IDXW-1:0]   pick_idx;
    logic [IDXW-1:0]   cand;
    logic              valid_g;
    logic              beat;
    logic [DWIDTH-1:0] sel_data;

    // Rotating-priority search starting at rr_ptr_q.
    // NOTE: every always_comb output gets a default on entry so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDXW'((int'(rr_ptr_q) + k) % NREQ);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Beat is combinational so the producer sees ready in the same cycle it
    // drives valid; rst suppresses it so no write escapes in the reset cycle.
    assign valid_g = bus.req_valid[gnt_idx_q];
    assign beat    = (state_q == ST_GRANT) && valid_g && !bus.fifo_full && !rst;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx_q == IDXW'(i)) sel_data = bus.req_data[i*DWIDTH +: DWIDTH];
        end
    end

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = beat && (gnt_idx_q == IDXW'(i));
        end
    end

    assign bus.fifo_w_en = beat;
    assign bus.fifo_din  = (busy_q && !rst) ? sel_data : '0;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gnt_idx_q  <= '0;
            beat_cnt_q <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_q    <= ST_GRANT;
                        gnt_idx_q  <= pick_idx;
                        gnt_q      <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        busy_q     <= 1'b1;
                        beat_cnt_q <= '0;
                    end
                end
                ST_GRANT: begin
                    // Release on a withdrawn valid or on the last beat of the
                    // burst; a full stall leaves everything untouched.
                    if (!valid_g || (beat && beat_cnt_q == LAST_BEAT)) begin
                        state_q    <= ST_IDLE;
                        gnt_q      <= '0;
                        busy_q     <= 1'b0;
                        beat_cnt_q <= '0;
                        rr_ptr_q   <= (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + 1'b1;
                    end else if (beat) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] beat_total_q;
    logic        stall;

    assign stall = (state_q == ST_GRANT) && valid_g && bus.fifo_full;

    // Saturating counters: they stick at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            beat_total_q <= '0;
        end else begin
            if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (beat && beat_total_q != 16'hFFFF) beat_total_q <= beat_total_q + 16'd1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign beat_total = beat_total_q;
`endif
endmodule
